totalzeros_dec: RTL and testbench

TOTALZEROS_DEC -- requirements
Module: totalzeros_dec

---
 rtl/totalzeros_dec_pkg.sv | 65 ++++++
 rtl/totalzeros_dec_tab.sv | 54 +++++
 rtl/totalzeros_dec.sv | 127 ++++++++++++
 tb/tb_totalzeros_dec.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/totalzeros_dec_pkg.sv
// Shared CAVLC constants for the total_zeros decoder:
// FSM encodings, maxNumCoeff values and codeword tables.
package totalzeros_dec_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DEC  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [4:0] MC_CDC  = 5'd4;
  localparam logic [4:0] MC_AC   = 5'd15;
  localparam logic [4:0] MC_LUMA = 5'd16;

  // 4x4 table, row = totalcoeff-1, column = total_zeros.
  // Zero length marks an unused slot.
  localparam int TZ_LEN [15][16] = '{
    '{1,3,3,4,4,5,5,6,6,7,7,8,8,9,9,9},
    '{3,3,3,3,3,4,4,4,4,5,5,6,6,6,6,0},
    '{4,3,3,3,4,4,3,3,4,5,5,6,5,6,0,0},
    '{5,3,4,4,3,3,3,4,3,4,5,5,5,0,0,0},
    '{4,4,4,3,3,3,3,3,4,5,4,5,0,0,0,0},
    '{6,5,3,3,3,3,3,3,4,3,6,0,0,0,0,0},
    '{6,5,3,3,3,2,3,4,3,6,0,0,0,0,0,0},
    '{6,4,5,3,2,2,3,3,6,0,0,0,0,0,0,0},
    '{6,6,4,2,2,3,2,5,0,0,0,0,0,0,0,0},
    '{5,5,3,2,2,2,4,0,0,0,0,0,0,0,0,0},
    '{4,4,3,3,1,3,0,0,0,0,0,0,0,0,0,0},
    '{4,4,2,1,3,0,0,0,0,0,0,0,0,0,0,0},
    '{3,3,1,2,0,0,0,0,0,0,0,0,0,0,0,0},
    '{2,2,1,0,0,0,0,0,0,0,0,0,0,0,0,0},
    '{1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0}
  };

  localparam int TZ_CODE [15][16] = '{
    '{1,3,2,3,2,3,2,3,2,3,2,3,2,3,2,1},
    '{7,6,5,4,3,5,4,3,2,3,2,3,2,1,0,0},
    '{5,7,6,5,4,3,4,3,2,3,2,1,1,0,0,0},
    '{3,7,5,4,6,5,4,3,3,2,2,1,0,0,0,0},
    '{5,4,3,7,6,5,4,3,2,1,1,0,0,0,0,0},
    '{1,1,7,6,5,4,3,2,1,1,0,0,0,0,0,0},
    '{1,1,5,4,3,3,2,1,1,0,0,0,0,0,0,0},
    '{1,1,1,3,3,2,2,1,0,0,0,0,0,0,0,0},
    '{1,0,1,3,2,1,1,1,0,0,0,0,0,0,0,0},
    '{1,0,1,3,2,1,1,0,0,0,0,0,0,0,0,0},
    '{0,1,1,2,1,3,0,0,0,0,0,0,0,0,0,0},
    '{0,1,1,1,1,0,0,0,0,0,0,0,0,0,0,0},
    '{0,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0},
    '{0,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0},
    '{0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0}
  };

  // Chroma DC table, row = totalcoeff-1.
  localparam int TZC_LEN [3][4] = '{
    '{1,2,3,3},
    '{1,2,2,0},
    '{1,1,0,0}
  };

  localparam int TZC_CODE [3][4] = '{
    '{1,1,1,0},
    '{1,1,0,0},
    '{1,0,0,0}
  };

endpackage

// File: rtl/totalzeros_dec_tab.sv
// Combinational total_zeros codeword lookup.
// Matches the window prefix against one table row.
module totalzeros_dec_tab #(
  parameter int WIN_W = 9
) (
  input  logic             i_chroma,
  input  logic [4:0]       i_tc,
  input  logic [WIN_W-1:0] i_win,
  output logic [3:0]       o_tz,
  output logic [3:0]       o_len,
  output logic             o_match
);
  import totalzeros_dec_pkg::*;

  logic [3:0] w_row;
  logic       w_cdc_ok;
  logic       w_blk_ok;

  assign w_row    = i_tc[3:0] - 4'd1;
  assign w_cdc_ok = (i_tc >= 5'd1) && (i_tc <= 5'd3);
  assign w_blk_ok = (i_tc >= 5'd1) && (i_tc <= 5'd15);

  // Codes are prefix-free, so at most one entry can hit.
  always_comb begin
    logic hit;
    int   l;
    int   c;
    o_tz    = '0;
    o_len   = '0;
    o_match = 1'b0;
    hit     = 1'b0;
    l       = 0;
    c       = 0;
    for (int z = 0; z < 16; z++) begin
      l = 0;
      c = 0;
      if (i_chroma && w_cdc_ok && z < 4) begin
        l = TZC_LEN[w_row[1:0]][z];
        c = TZC_CODE[w_row[1:0]][z];
      end else if (!i_chroma && w_blk_ok) begin
        l = TZ_LEN[w_row][z];
        c = TZ_CODE[w_row][z];
      end
      if (!hit && l != 0 &&
          (i_win >> (WIN_W - l)) == WIN_W'(c)) begin
        hit   = 1'b1;
        o_tz  = 4'(z);
        o_len = 4'(l);
      end
    end
    o_match = hit;
  end

endmodule

// File: rtl/totalzeros_dec.sv
// total_zeros decoder: latch request, wait for bits,
// look up codeword, strobe done with held result.
module totalzeros_dec #(
  parameter int WIN_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       totalcoeff,
  input  logic [4:0]       max_coeff,
  input  logic [WIN_W-1:0] bits,
  input  logic             bits_valid,
  output logic             busy,
  output logic             done,
  output logic [3:0]       totalzeros,
  output logic [3:0]       zeros_len,
  output logic             err
);
  import totalzeros_dec_pkg::*;

  logic [1:0]       r_state;
  logic [4:0]       r_tc;
  logic [4:0]       r_mc;
  logic [WIN_W-1:0] r_bits;
  logic [3:0]       r_tz;
  logic [3:0]       r_len;
  logic             r_err;

  logic             w_mc_ok;
  logic             w_bad;
  logic             w_full;
  logic             w_skip;
  logic [4:0]       w_room;
  logic [3:0]       w_tz;
  logic [3:0]       w_len;
  logic             w_match;
  logic             w_hit;

  assign w_mc_ok = (r_mc == MC_CDC) ||
                   (r_mc == MC_AC)  ||
                   (r_mc == MC_LUMA);
  assign w_bad   = !w_mc_ok || (r_tc == 5'd0) ||
                   (r_tc > r_mc);
  assign w_full  = !w_bad && (r_tc == r_mc);
  assign w_skip  = w_bad || w_full;
  // Safe from wrap: only used when !w_bad.
  assign w_room  = r_mc - r_tc;
  // AC blocks share the luma table but allow one
  // fewer zero, so the range check is still needed.
  assign w_hit   = !w_skip && w_match &&
                   ({1'b0, w_tz} <= w_room);

  totalzeros_dec_tab #(
    .WIN_W (WIN_W)
  ) u_tab (
    .i_chroma (r_mc == MC_CDC),
    .i_tc     (r_tc),
    .i_win    (r_bits),
    .o_tz     (w_tz),
    .o_len    (w_len),
    .o_match  (w_match)
  );

  // Request FSM with registered lookup result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tc    <= '0;
      r_mc    <= '0;
      r_bits  <= '0;
      r_tz    <= '0;
      r_len   <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_tc    <= totalcoeff;
            r_mc    <= max_coeff;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_skip) begin
            r_state <= ST_DEC;
          end else if (bits_valid) begin
            r_bits  <= bits;
            r_state <= ST_DEC;
          end
        end
        ST_DEC: begin
          r_state <= ST_DONE;
          unique case (1'b1)
            w_full: begin
              r_err <= 1'b0;
              r_tz  <= '0;
              r_len <= '0;
            end
            w_hit: begin
              r_err <= 1'b0;
              r_tz  <= w_tz;
              r_len <= w_len;
            end
            default: begin
              r_err <= 1'b1;
              r_tz  <= '0;
              r_len <= '0;
            end
          endcase
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign totalzeros = r_tz;
  assign zeros_len  = r_len;
  assign err        = r_err;

endmodule

// File: tb/tb_totalzeros_dec.sv
// Randomised bench for totalzeros_dec against a
// prefix-search reference model over the code tables.
module tb_totalzeros_dec;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] totalcoeff;
  logic [4:0] max_coeff;
  logic [8:0] bits;
  logic       bits_valid;
  logic       busy;
  logic       done;
  logic [3:0] totalzeros;
  logic [3:0] zeros_len;
  logic       err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  totalzeros_dec #(.WIN_W(9)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .totalcoeff (totalcoeff),
    .max_coeff  (max_coeff),
    .bits       (bits),
    .bits_valid (bits_valid),
    .busy       (busy),
    .done       (done),
    .totalzeros (totalzeros),
    .zeros_len  (zeros_len),
    .err        (err)
  );

  // Encoder tables (length, value) per [tc-1][tz].
  localparam int EL [15][16] = '{
    '{1,3,3,4,4,5,5,6,6,7,7,8,8,9,9,9},
    '{3,3,3,3,3,4,4,4,4,5,5,6,6,6,6,0},
    '{4,3,3,3,4,4,3,3,4,5,5,6,5,6,0,0},
    '{5,3,4,4,3,3,3,4,3,4,5,5,5,0,0,0},
    '{4,4,4,3,3,3,3,3,4,5,4,5,0,0,0,0},
    '{6,5,3,3,3,3,3,3,4,3,6,0,0,0,0,0},
    '{6,5,3,3,3,2,3,4,3,6,0,0,0,0,0,0},
    '{6,4,5,3,2,2,3,3,6,0,0,0,0,0,0,0},
    '{6,6,4,2,2,3,2,5,0,0,0,0,0,0,0,0},
    '{5,5,3,2,2,2,4,0,0,0,0,0,0,0,0,0},
    '{4,4,3,3,1,3,0,0,0,0,0,0,0,0,0,0},
    '{4,4,2,1,3,0,0,0,0,0,0,0,0,0,0,0},
    '{3,3,1,2,0,0,0,0,0,0,0,0,0,0,0,0},
    '{2,2,1,0,0,0,0,0,0,0,0,0,0,0,0,0},
    '{1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0}
  };
  localparam int EV [15][16] = '{
    '{1,3,2,3,2,3,2,3,2,3,2,3,2,3,2,1},
    '{7,6,5,4,3,5,4,3,2,3,2,3,2,1,0,0},
    '{5,7,6,5,4,3,4,3,2,3,2,1,1,0,0,0},
    '{3,7,5,4,6,5,4,3,3,2,2,1,0,0,0,0},
    '{5,4,3,7,6,5,4,3,2,1,1,0,0,0,0,0},
    '{1,1,7,6,5,4,3,2,1,1,0,0,0,0,0,0},
    '{1,1,5,4,3,3,2,1,1,0,0,0,0,0,0,0},
    '{1,1,1,3,3,2,2,1,0,0,0,0,0,0,0,0},
    '{1,0,1,3,2,1,1,1,0,0,0,0,0,0,0,0},
    '{1,0,1,3,2,1,1,0,0,0,0,0,0,0,0,0},
    '{0,1,1,2,1,3,0,0,0,0,0,0,0,0,0,0},
    '{0,1,1,1,1,0,0,0,0,0,0,0,0,0,0,0},
    '{0,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0},
    '{0,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0},
    '{0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0}
  };
  localparam int CL [3][4] = '{'{1,2,3,3},'{1,2,2,0},'{1,1,0,0}};
  localparam int CV [3][4] = '{'{1,1,1,0},'{1,1,0,0},'{1,0,0,0}};

  function automatic void code_of(input int mc, input int tc,
                                  input int tz, output int l,
                                  output int v);
    if (mc == 4) begin
      l = CL[tc-1][tz];
      v = CV[tc-1][tz];
    end else begin
      l = EL[tc-1][tz];
      v = EV[tc-1][tz];
    end
  endfunction

  function automatic bit skips(input int mc, input int tc);
    return !(mc == 4 || mc == 15 || mc == 16) ||
           tc == 0 || tc >= mc;
  endfunction

  // Search the legal codeword set for a prefix of the window.
  function automatic void model(input int mc, input int tc,
                                input logic [8:0] b,
                                output int tz, output int len,
                                output bit e);
    int l;
    int v;
    tz = 0;
    len = 0;
    e = 1'b1;
    if (!(mc == 4 || mc == 15 || mc == 16) || tc == 0 || tc > mc)
      return;
    if (tc == mc) begin
      e = 1'b0;
      return;
    end
    for (int z = 0; z <= mc - tc; z++) begin
      code_of(mc, tc, z, l, v);
      if (l > 0 && int'(b >> (9 - l)) == v) begin
        tz = z;
        len = l;
        e = 1'b0;
        return;
      end
    end
  endfunction

  function automatic logic [8:0] encode(input int l, input int v);
    logic [8:0] pad;
    pad = 9'($urandom) & 9'((1 << (9 - l)) - 1);
    return 9'(v << (9 - l)) | pad;
  endfunction

  // Issue one request; bits_valid rises at cycle bv_at.
  task automatic run_req(input int mc, input int tc,
                         input logic [8:0] b, input int bv_at,
                         input bit poke, output int dcyc,
                         output logic [3:0] otz,
                         output logic [3:0] olen,
                         output logic oerr);
    @(negedge clk);
    start = 1'b1;
    totalcoeff = 5'(tc);
    max_coeff = 5'(mc);
    bits = b;
    bits_valid = (bv_at == 0);
    dcyc = -1;
    otz = 'x;
    olen = 'x;
    oerr = 1'bx;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = poke && (c == 2);
      if (poke && c == 2) begin
        totalcoeff = 5'(tc ^ 3);
        max_coeff = 5'd16;
      end
      if (c >= bv_at) bits_valid = 1'b1;
      if (done) begin
        dcyc = c;
        otz = totalzeros;
        olen = zeros_len;
        oerr = err;
        break;
      end
    end
    start = 1'b0;
    bits_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total += 5;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy got=%b exp=0", busy);
    end
    if (done !== 1'b0) begin
      bad++; $display("FAIL reset_done got=%b exp=0", done);
    end
    if (err !== 1'b0) begin
      bad++; $display("FAIL reset_err got=%b exp=0", err);
    end
    if (totalzeros !== 4'd0) begin
      bad++; $display("FAIL reset_tz got=%0d exp=0", totalzeros);
    end
    if (zeros_len !== 4'd0) begin
      bad++; $display("FAIL reset_len got=%0d exp=0", zeros_len);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int dc;
    logic [3:0] tz, ln;
    logic e;
    run_req(16, 1, encode(3, 3'b011), 0, 0, dc, tz, ln, e);
    total++;
    if (dc != 3 || tz !== 4'd1 || ln !== 4'd3 || e !== 1'b0) begin
      bad++;
      $display("FAIL basic got cyc=%0d tz=%0d len=%0d err=%b exp 3/1/3/0",
               dc, tz, ln, e);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || totalzeros !== 4'd1 ||
        zeros_len !== 4'd3) begin
      bad++;
      $display("FAIL after_done got done=%b busy=%b tz=%0d len=%0d exp 0/0/1/3",
               done, busy, totalzeros, zeros_len);
    end
  endtask

  task automatic test_long_code();
    int dc;
    logic [3:0] tz, ln;
    logic e;
    run_req(16, 1, 9'b000000001, 0, 0, dc, tz, ln, e);
    total++;
    if (dc != 3 || tz !== 4'd15 || ln !== 4'd9 || e !== 1'b0) begin
      bad++;
      $display("FAIL len9 got cyc=%0d tz=%0d len=%0d err=%b exp 3/15/9/0",
               dc, tz, ln, e);
    end
    run_req(16, 1, 9'b000000000, 0, 0, dc, tz, ln, e);
    total++;
    if (dc != 3 || ln !== 4'd0 || e !== 1'b1) begin
      bad++;
      $display("FAIL nomatch got cyc=%0d len=%0d err=%b exp 3/0/1",
               dc, ln, e);
    end
  endtask

  task automatic test_chroma();
    logic [8:0] bv [5];
    int tcs [5];
    int etz [5];
    int eln [5];
    int dc;
    logic [3:0] tz, ln;
    logic e;
    bv = '{9'b100000000, 9'b010000000, 9'b001000000,
           9'b000000000, 9'b000000000};
    tcs = '{1, 1, 1, 1, 3};
    etz = '{0, 1, 2, 3, 1};
    eln = '{1, 2, 3, 3, 1};
    for (int i = 0; i < 5; i++) begin
      run_req(4, tcs[i], bv[i] | 9'($urandom_range(0, 31)) & 9'h03f
              & ~(9'h1ff << (9 - eln[i])) & 9'h000,
              0, 0, dc, tz, ln, e);
      total++;
      if (dc != 3 || tz !== 4'(etz[i]) || ln !== 4'(eln[i]) ||
          e !== 1'b0) begin
        bad++;
        $display("FAIL chroma%0d got tz=%0d len=%0d err=%b exp %0d/%0d/0",
                 i, tz, ln, e, etz[i], eln[i]);
      end
    end
  endtask

  task automatic test_bypass();
    int dc;
    logic [3:0] tz, ln;
    logic e;
    run_req(15, 15, 9'($urandom), 1000, 0, dc, tz, ln, e);
    total++;
    if (dc != 3 || tz !== 4'd0 || ln !== 4'd0 || e !== 1'b0) begin
      bad++;
      $display("FAIL full got cyc=%0d tz=%0d len=%0d err=%b exp 3/0/0/0",
               dc, tz, ln, e);
    end
    run_req(15, 0, 9'($urandom), 1000, 0, dc, tz, ln, e);
    total++;
    if (dc != 3 || tz !== 4'd0 || ln !== 4'd0 || e !== 1'b1) begin
      bad++;
      $display("FAIL tc0 got cyc=%0d tz=%0d len=%0d err=%b exp 3/0/0/1",
               dc, tz, ln, e);
    end
  endtask

  task automatic test_wait_bits();
    int dc, mtz, mln;
    bit me;
    logic [3:0] tz, ln;
    logic e;
    logic [8:0] b;
    b = 9'($urandom);
    model(16, 5, b, mtz, mln, me);
    run_req(16, 5, b, 6, 0, dc, tz, ln, e);
    total++;
    if (dc != 8 || tz !== 4'(mtz) || ln !== 4'(mln) || e !== me) begin
      bad++;
      $display("FAIL wait_bits got cyc=%0d tz=%0d len=%0d err=%b exp 8/%0d/%0d/%b",
               dc, tz, ln, e, mtz, mln, me);
    end
  endtask

  task automatic test_busy_start();
    int dc, mtz, mln;
    bit me;
    logic [3:0] tz, ln;
    logic e;
    logic [8:0] b;
    for (int i = 0; i < 4; i++) begin
      b = 9'($urandom);
      model(15, 2 + i, b, mtz, mln, me);
      run_req(15, 2 + i, b, 4, 1, dc, tz, ln, e);
      total++;
      if (dc != 6 || tz !== 4'(mtz) || ln !== 4'(mln) || e !== me) begin
        bad++;
        $display("FAIL busy_start got cyc=%0d tz=%0d len=%0d err=%b exp 6/%0d/%0d/%b",
                 dc, tz, ln, e, mtz, mln, me);
      end
    end
  endtask

  task automatic test_rst_mid();
    bit seen;
    int dc;
    @(negedge clk);
    start = 1'b1;
    totalcoeff = 5'd1;
    max_coeff = 5'd16;
    bits = 9'b011000000;
    bits_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bits_valid = 1'b1;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL rst_busy got=%b exp=0", busy);
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    bits_valid = 1'b0;
    total++;
    if (seen) begin
      bad++; $display("FAIL rst_no_done got done=1 exp none");
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    totalcoeff = 5'd2;
    max_coeff = 5'd4;
    bits = 9'b010000000;
    bits_valid = 1'b1;
    dc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        dc = c;
        break;
      end
    end
    bits_valid = 1'b0;
    total++;
    if (dc != 3 || totalzeros !== 4'd1 || zeros_len !== 4'd2 ||
        err !== 1'b0) begin
      bad++;
      $display("FAIL start_after_rst got cyc=%0d tz=%0d len=%0d err=%b exp 3/1/2/0",
               dc, totalzeros, zeros_len, err);
    end
  endtask

  task automatic test_loopback();
    int mcs [3];
    int l, v, dc;
    logic [3:0] tz, ln;
    logic e;
    mcs = '{4, 15, 16};
    foreach (mcs[m]) begin
      for (int tc = 1; tc < mcs[m]; tc++) begin
        for (int z = 0; z <= mcs[m] - tc; z++) begin
          code_of(mcs[m], tc, z, l, v);
          run_req(mcs[m], tc, encode(l, v), 0, 0, dc, tz, ln, e);
          total++;
          if (dc != 3 || tz !== 4'(z) || ln !== 4'(l) || e !== 1'b0) begin
            bad++;
            $display("FAIL loop mc=%0d tc=%0d got cyc=%0d tz=%0d len=%0d err=%b exp 3/%0d/%0d/0",
                     mcs[m], tc, dc, tz, ln, e, z, l);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    int mc, tc, bva, dc, mtz, mln, edc;
    bit me;
    logic [3:0] tz, ln;
    logic e;
    logic [8:0] b;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: mc = 4;
        1: mc = 15;
        2: mc = 16;
        default: mc = int'($urandom_range(0, 31));
      endcase
      tc = int'($urandom_range(0, 17));
      b = 9'($urandom);
      bva = int'($urandom_range(0, 3));
      model(mc, tc, b, mtz, mln, me);
      edc = skips(mc, tc) ? 3 : ((bva < 1 ? 1 : bva) + 2);
      run_req(mc, tc, b, bva, 0, dc, tz, ln, e);
      total++;
      if (dc != edc || tz !== 4'(mtz) || ln !== 4'(mln) || e !== me) begin
        bad++;
        $display("FAIL rand mc=%0d tc=%0d b=%b got cyc=%0d tz=%0d len=%0d err=%b exp %0d/%0d/%0d/%b",
                 mc, tc, b, dc, tz, ln, e, edc, mtz, mln, me);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    totalcoeff = '0;
    max_coeff = '0;
    bits = '0;
    bits_valid = 1'b0;
    test_reset();
    test_basic();
    test_long_code();
    test_chroma();
    test_bypass();
    test_wait_bits();
    test_busy_start();
    test_rst_mid();
    test_loopback();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
